// File: rtl/rib_arbiter_pkg.sv
// Shared constants and helpers for the RIB bus arbiter.
// Master indices, FSM state encoding and default timeout.
package rib_arbiter_pkg;

    localparam int RIB_M0 = 0;
    localparam int RIB_M1 = 1;
    localparam int RIB_M2 = 2;
    localparam int RIB_M3 = 3;

    localparam int RIB_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        RIB_ARB_IDLE = 2'd0,
        RIB_ARB_BUSY = 2'd1,
        RIB_ARB_DONE = 2'd2
    } arb_state_e;

    // Successor in the m0 -> m1 -> m3 -> m0 rotation.
    function automatic logic [1:0] rr_next(input logic [1:0] x);
        case (x)
            2'd0:    return 2'd1;
            2'd1:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        case (oh)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/rib_arbiter_if.sv
// Master-side and slave-side signal bundle of the RIB arbiter.
// The arbiter uses the master modport; its environment uses slave.
interface rib_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          m_req_i;
    logic [3:0]          m_we_i;
    logic [4*ADDR_W-1:0] m_addr_i;
    logic [4*DATA_W-1:0] m_data_i;
    logic [3:0]          m_ack_o;
    logic [3:0]          m_err_o;
    logic [DATA_W-1:0]   m_data_o;
    logic [3:0]          grant_o;
    logic                bus_req_o;
    logic                bus_we_o;
    logic [ADDR_W-1:0]   bus_addr_o;
    logic [DATA_W-1:0]   bus_data_o;
    logic [DATA_W-1:0]   bus_data_i;
    logic                bus_ack_i;
    logic                hold_flag_o;

    modport master (
        input  m_req_i, m_we_i, m_addr_i, m_data_i,
        input  bus_data_i, bus_ack_i,
        output m_ack_o, m_err_o, m_data_o, grant_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_data_o,
        output hold_flag_o
    );

    modport slave (
        output m_req_i, m_we_i, m_addr_i, m_data_i,
        output bus_data_i, bus_ack_i,
        input  m_ack_o, m_err_o, m_data_o, grant_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_data_o,
        input  hold_flag_o
    );
endinterface

// File: rtl/rib_rr_pick.sv
// Combinational winner select: JTAG (m2) overrides, otherwise
// round-robin over m0 -> m1 -> m3 starting at rr_ptr_i.
module rib_rr_pick
    import rib_arbiter_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] rr_ptr_i,
    output logic [3:0] win_o
);
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;

    always_comb begin
        a = 2'd0;
        b = 2'd1;
        c = 2'd3;
        case (rr_ptr_i)
            2'd1: begin a = 2'd1; b = 2'd3; c = 2'd0; end
            2'd3: begin a = 2'd3; b = 2'd0; c = 2'd1; end
            default: ;
        endcase
    end

    always_comb begin
        win_o = '0;
        if (req_i[RIB_M2])  win_o[RIB_M2] = 1'b1;
        else if (req_i[a])  win_o[a] = 1'b1;
        else if (req_i[b])  win_o[b] = 1'b1;
        else if (req_i[c])  win_o[c] = 1'b1;
    end

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter: one transaction at a time, IDLE -> BUSY -> DONE,
// with per-transaction timeout and core hold for non-core owners.
module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = RIB_TIMEOUT_DEF
) (
    input logic             clk,
    input logic             rst,
    rib_arbiter_if.master   bus
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_e        state_q;
    logic [3:0]        grant_q;
    logic [3:0]        ack_q;
    logic [3:0]        err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rr_q;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic [3:0]        pick;

    rib_rr_pick u_pick (
        .req_i    (bus.m_req_i),
        .rr_ptr_i (rr_q),
        .win_o    (pick)
    );

    assign cnt_d = cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RIB_ARB_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            rr_q    <= 2'(RIB_M0);
            cnt_q   <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            unique case (state_q)
                RIB_ARB_IDLE: begin
                    if (|bus.m_req_i) begin
                        grant_q <= pick;
                        cnt_q   <= '0;
                        state_q <= RIB_ARB_BUSY;
                    end
                end
                RIB_ARB_BUSY: begin
                    if (bus.bus_ack_i) begin
                        rdata_q <= bus.bus_data_i;
                        ack_q   <= grant_q;
                        state_q <= RIB_ARB_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        rdata_q <= '0;
                        ack_q   <= grant_q;
                        err_q   <= grant_q;
                        state_q <= RIB_ARB_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RIB_ARB_DONE: begin
                    // JTAG grants do not advance the rotation.
                    if (!grant_q[RIB_M2])
                        rr_q <= rr_next(oh2idx(grant_q));
                    grant_q <= '0;
                    state_q <= RIB_ARB_IDLE;
                end
                default: state_q <= RIB_ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.bus_we_o   = 1'b0;
        bus.bus_addr_o = '0;
        bus.bus_data_o = '0;
        for (int n = 0; n < 4; n++) begin
            if (grant_q[n]) begin
                bus.bus_we_o   = bus.bus_we_o | bus.m_we_i[n];
                bus.bus_addr_o = bus.bus_addr_o
                               | bus.m_addr_i[n*ADDR_W +: ADDR_W];
                bus.bus_data_o = bus.bus_data_o
                               | bus.m_data_i[n*DATA_W +: DATA_W];
            end
        end
    end

    // grant_q is nonzero only in BUSY/DONE, so the m0 term stalls
    // the core only while another master owns the bus.
    assign bus.hold_flag_o = grant_q[RIB_M2] | grant_q[RIB_M3]
                           | (bus.m_req_i[RIB_M0] & (|grant_q)
                              & ~grant_q[RIB_M0]);

    assign bus.bus_req_o = (state_q == RIB_ARB_BUSY);
    assign bus.grant_o   = grant_q;
    assign bus.m_ack_o   = ack_q;
    assign bus.m_err_o   = err_q;
    assign bus.m_data_o  = rdata_q;

endmodule
